// File: rtl/mul_accum_if.sv
// mul_accum_if - stream bundle between a product source and mul_accum.
//   Input side : in_valid / in_ready / in_prod / in_last (product beats)
//   Output side: out_valid / out_ready / out_acc / out_cnt / out_ovf (frame result)
//   master modport: the environment (drives beats, takes results)
//   slave  modport: the accumulator block
interface mul_accum_if #(
    parameter int PROD_W = 12,
    parameter int ACC_W  = 16,
    parameter int CNT_W  = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_prod;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_acc;
    logic [CNT_W-1:0]  out_cnt;
    logic              out_ovf;

    modport master (
        output in_valid, in_prod, in_last, out_ready,
        input  in_ready, out_valid, out_acc, out_cnt, out_ovf
    );

    modport slave (
        input  in_valid, in_prod, in_last, out_ready,
        output in_ready, out_valid, out_acc, out_cnt, out_ovf
    );
endinterface

// File: rtl/mul_accum.sv
// mul_accum - saturating signed multiply-accumulate back end.
//   Accepts two's-complement products, sums them into a saturating signed
//   accumulator, and presents sum / beat count / overflow flag when a frame
//   ends (in_last), holding them until out_ready.
// Ports:
//   clk   - system clock, rising edge
//   rst   - synchronous active-high reset
//   clear - synchronous frame abort (zeroes registers, drops held result)
//   bus   - mul_accum_if slave modport (beat input and result output)
module mul_accum #(
    parameter int PROD_W = 12,
    parameter int ACC_W  = 16,
    parameter int CNT_W  = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    mul_accum_if.slave bus
);
    typedef enum logic {ST_ACCUM = 1'b0, ST_HOLD = 1'b1} state_t;

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;

    state_t           w_state_next;
    logic [ACC_W-1:0] w_acc_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_ovf_next;

    logic             w_accept;
    logic [ACC_W:0]   w_prod_ext;
    logic [ACC_W:0]   w_sum;
    logic             w_sat;

    // Sign-extend the product to the one-bit-wider sum width.
    for (genvar gi = 0; gi <= ACC_W; gi++) begin : g_ext
        if (gi < PROD_W) begin : g_lo
            assign w_prod_ext[gi] = bus.in_prod[gi];
        end else begin : g_hi
            assign w_prod_ext[gi] = bus.in_prod[PROD_W-1];
        end
    end

    assign w_accept = bus.in_valid && (r_state == ST_ACCUM);
    assign w_sum    = {r_acc[ACC_W-1], r_acc} + w_prod_ext;
    // Out of range exactly when the two top bits of the wide sum disagree;
    // the top bit then gives the direction.
    assign w_sat    = w_sum[ACC_W] ^ w_sum[ACC_W-1];

    always_comb begin
        w_state_next = r_state;
        w_acc_next   = r_acc;
        w_cnt_next   = r_cnt;
        w_ovf_next   = r_ovf;
        if (clear) begin
            // A beat offered alongside clear is consumed (in_ready is high) and dropped.
            w_state_next = ST_ACCUM;
            w_acc_next   = '0;
            w_cnt_next   = '0;
            w_ovf_next   = 1'b0;
        end else if (r_state == ST_ACCUM) begin
            if (w_accept) begin
                if (w_sat) begin
                    w_acc_next = w_sum[ACC_W] ? ACC_MIN : ACC_MAX;
                    w_ovf_next = 1'b1;
                end else begin
                    w_acc_next = w_sum[ACC_W-1:0];
                end
                if (r_cnt != {CNT_W{1'b1}}) begin
                    w_cnt_next = r_cnt + CNT_ONE;
                end
                if (bus.in_last) begin
                    w_state_next = ST_HOLD;
                end
            end
        end else begin
            if (bus.out_ready) begin
                w_state_next = ST_ACCUM;
                w_acc_next   = '0;
                w_cnt_next   = '0;
                w_ovf_next   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ACCUM;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_acc   <= w_acc_next;
            r_cnt   <= w_cnt_next;
            r_ovf   <= w_ovf_next;
        end
    end

    // Handshake outputs come from state only; no path from out_ready to in_ready.
    assign bus.in_ready  = (r_state == ST_ACCUM);
    assign bus.out_valid = (r_state == ST_HOLD);
    assign bus.out_acc   = r_acc;
    assign bus.out_cnt   = r_cnt;
    assign bus.out_ovf   = r_ovf;
endmodule

// File: tb/tb_mul_accum.sv
module tb_mul_accum;
    localparam int PROD_W = 12;
    localparam int ACC_W  = 16;
    localparam int CNT_W  = 8;
    localparam int AMAX   = 32767;
    localparam int AMIN   = -32768;
    localparam int CMAX   = 255;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clear = 1'b0;

    mul_accum_if #(.PROD_W(PROD_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

    mul_accum #(.PROD_W(PROD_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Behavioural model: plain integers following the frame rules.
    int m_acc = 0;
    int m_cnt = 0;
    bit m_ovf = 1'b0;
    bit m_hold = 1'b0;

    always @(posedge clk) begin
        int s;
        if (rst) begin
            m_acc = 0; m_cnt = 0; m_ovf = 0; m_hold = 0;
        end else if (clear) begin
            m_acc = 0; m_cnt = 0; m_ovf = 0; m_hold = 0;
        end else if (!m_hold) begin
            if (bus.in_valid) begin
                s = m_acc + int'($signed(bus.in_prod));
                if (s > AMAX) begin m_acc = AMAX; m_ovf = 1; end
                else if (s < AMIN) begin m_acc = AMIN; m_ovf = 1; end
                else m_acc = s;
                if (m_cnt < CMAX) m_cnt = m_cnt + 1;
                if (bus.in_last) m_hold = 1;
            end
        end else if (bus.out_ready) begin
            m_acc = 0; m_cnt = 0; m_ovf = 0; m_hold = 0;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_in_ready", int'(bus.in_ready), int'(!m_hold));
            check("cyc_out_valid", int'(bus.out_valid), int'(m_hold));
            check("cyc_out_acc", int'($signed(bus.out_acc)), m_acc);
            check("cyc_out_cnt", int'(bus.out_cnt), m_cnt);
            check("cyc_out_ovf", int'(bus.out_ovf), int'(m_ovf));
        end
    end

    task automatic idle();
        bus.in_valid = 0; bus.in_last = 0; bus.out_ready = 0; clear = 0;
    endtask

    task automatic beat(input int p, input bit last);
        bus.in_valid = 1;
        bus.in_prod  = PROD_W'(p);
        bus.in_last  = last;
        @(negedge clk);
        bus.in_valid = 0;
        bus.in_last  = 0;
    endtask

    task automatic take_result(input string tag, input int acc, input int cnt, input int ovf);
        check({tag, "_valid"}, int'(bus.out_valid), 1);
        check({tag, "_ready_low"}, int'(bus.in_ready), 0);
        check({tag, "_acc"}, int'($signed(bus.out_acc)), acc);
        check({tag, "_cnt"}, int'(bus.out_cnt), cnt);
        check({tag, "_ovf"}, int'(bus.out_ovf), ovf);
        $display("frame %s acc=%0d cnt=%0d ovf=%0d", tag,
                 $signed(bus.out_acc), bus.out_cnt, bus.out_ovf);
        bus.out_ready = 1;
        @(negedge clk);
        bus.out_ready = 0;
        check({tag, "_ready_back"}, int'(bus.in_ready), 1);
        check({tag, "_valid_drop"}, int'(bus.out_valid), 0);
    endtask

    initial begin
        idle();
        bus.in_prod = '0;
        repeat (2) @(negedge clk);
        rst = 0;
        chk_en = 1;
        check("rst_in_ready", int'(bus.in_ready), 1);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_acc", int'(bus.out_acc), 0);

        // Basic frame
        beat(-15, 0); beat(20, 0); beat(6, 1);
        take_result("basic", 11, 3, 0);

        // Positive saturation
        for (int i = 0; i < 34; i++) beat(961, 0);
        check("pos_pre_acc", int'($signed(bus.out_acc)), 32674);
        check("pos_pre_ovf", int'(bus.out_ovf), 0);
        beat(961, 1);
        take_result("possat", 32767, 35, 1);

        // Negative saturation
        for (int i = 0; i < 33; i++) beat(-992, 0);
        check("neg_pre_acc", int'($signed(bus.out_acc)), -32736);
        beat(-992, 1);
        take_result("negsat", -32768, 34, 1);

        // Backpressure in HOLD with beats offered
        beat(5, 1);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1; bus.in_prod = PROD_W'($urandom); bus.in_last = 1;
            @(negedge clk);
            check("bp_acc", int'($signed(bus.out_acc)), 5);
            check("bp_cnt", int'(bus.out_cnt), 1);
            check("bp_in_ready", int'(bus.in_ready), 0);
        end
        idle();
        take_result("bp", 5, 1, 0);
        beat(3, 1);
        take_result("after_bp", 3, 1, 0);

        // clear mid-frame
        beat(100, 0); beat(200, 0);
        clear = 1; @(negedge clk); clear = 0;
        beat(7, 1);
        take_result("clr_mid", 7, 1, 0);

        // clear with a beat in the same cycle: beat is discarded
        beat(50, 0);
        clear = 1; beat(99, 0); clear = 0;
        beat(1, 1);
        take_result("clr_beat", 1, 1, 0);

        // clear in HOLD with out_ready low
        beat(9, 1);
        check("clr_hold_pre", int'(bus.out_valid), 1);
        clear = 1; @(negedge clk); clear = 0;
        check("clr_hold_valid", int'(bus.out_valid), 0);
        check("clr_hold_acc", int'(bus.out_acc), 0);

        // rst mid-frame with a last beat offered
        beat(10, 0);
        rst = 1; bus.in_valid = 1; bus.in_last = 1; bus.in_prod = 12'd5;
        @(negedge clk);
        rst = 0; idle();
        check("rst_mid_valid", int'(bus.out_valid), 0);
        check("rst_mid_acc", int'(bus.out_acc), 0);
        check("rst_mid_cnt", int'(bus.out_cnt), 0);
        check("rst_mid_ready", int'(bus.in_ready), 1);

        // Counter saturation
        for (int i = 0; i < 299; i++) beat(int'($urandom_range(0, 4)) - 2, 0);
        beat(0, 1);
        check("cnt_sat", int'(bus.out_cnt), 255);
        bus.out_ready = 1; @(negedge clk); bus.out_ready = 0;

        // Randomized traffic, checked per cycle by the model
        for (int i = 0; i < 3000; i++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_prod   = PROD_W'($urandom);
            bus.in_last   = ($urandom_range(0, 15) == 0);
            bus.out_ready = ($urandom_range(0, 2) == 0);
            clear         = ($urandom_range(0, 63) == 0);
            @(negedge clk);
        end
        idle();
        @(negedge clk);
        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
